// File: rtl/imem_port_arbiter.sv
// Two-requester arbiter for the single combinational instruction-ROM read port.
// DS has priority; a saturating wait counter forces an IF grant after MAX_WAIT losses.
module imem_port_arbiter #(
   parameter int BITS     = 32,
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 8192,
   parameter int MAX_WAIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_req,
   input  logic [BITS-1:0]  if_addr,
   output logic             if_gnt,
   output logic             if_rvalid,
   output logic [WIDTH-1:0] if_rdata,
   output logic             if_err,
   input  logic             ds_req,
   input  logic [BITS-1:0]  ds_addr,
   output logic             ds_gnt,
   output logic             ds_rvalid,
   output logic [WIDTH-1:0] ds_rdata,
   output logic             ds_err,
   output logic [BITS-1:0]  mem_addr,
   input  logic [WIDTH-1:0] mem_dout
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0]   WAIT_MAX  = CW'(MAX_WAIT);
   localparam logic [BITS-1:0] DEPTH_LIM = BITS'(DEPTH);

   typedef enum logic {OWN_IF = 1'b0, OWN_DS = 1'b1} owner_t;

   logic [CW-1:0]   wait_cnt;
   logic            force_if;
   logic            any_gnt_p0;
   logic [BITS-1:0] addr_p0;
   logic            err_p0;
   owner_t          owner_p1;
   logic            err_p1;
   logic            vld_p1;

   function automatic logic addr_fault(input logic [BITS-1:0] addr);
      logic [BITS-1:0] word_idx;
      word_idx = {2'b00, addr[BITS-1:2]};
      return (addr[1:0] != 2'b00) || (word_idx >= DEPTH_LIM);
   endfunction

   // Stage p0: combinational arbitration; grants are held low while in reset
   always_comb begin
      force_if   = (wait_cnt == WAIT_MAX);
      ds_gnt     = rst_n & ds_req & ~force_if;
      if_gnt     = rst_n & if_req & (~ds_req | force_if);
      any_gnt_p0 = if_gnt | ds_gnt;
      addr_p0    = if_gnt ? if_addr : ds_addr;
      err_p0     = addr_fault(addr_p0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (!if_req || if_gnt) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Stage p1: granted address drives the ROM, response returns next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr <= '0;
         owner_p1 <= OWN_IF;
         err_p1   <= 1'b0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= any_gnt_p0;
         if (any_gnt_p0) begin
            mem_addr <= addr_p0;
            owner_p1 <= if_gnt ? OWN_IF : OWN_DS;
            err_p1   <= err_p0;
         end
      end
   end

   always_comb begin
      if_rvalid = vld_p1 && (owner_p1 == OWN_IF);
      ds_rvalid = vld_p1 && (owner_p1 == OWN_DS);
      if_err    = if_rvalid & err_p1;
      ds_err    = ds_rvalid & err_p1;
      if_rdata  = (if_rvalid && !err_p1) ? mem_dout : '0;
      ds_rdata  = (ds_rvalid && !err_p1) ? mem_dout : '0;
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: reset, single port, contention, streaming, faults.
module tb_imem_port_arbiter;

   localparam int BITS = 32, WIDTH = 32, DEPTH = 8192, MAX_WAIT = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             if_req, ds_req;
   logic [BITS-1:0]  if_addr, ds_addr, mem_addr;
   logic             if_gnt, if_rvalid, if_err;
   logic             ds_gnt, ds_rvalid, ds_err;
   logic [WIDTH-1:0] if_rdata, ds_rdata, mem_dout;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] rom(input logic [BITS-1:0] idx);
      return 32'h5A00_0000 ^ (idx << 8) ^ idx ^ 32'h0000_0077;
   endfunction

   assign mem_dout = rom(mem_addr >> 2);

   imem_port_arbiter #(.BITS(BITS), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .ds_req(ds_req), .ds_addr(ds_addr), .ds_gnt(ds_gnt),
      .ds_rvalid(ds_rvalid), .ds_rdata(ds_rdata), .ds_err(ds_err),
      .mem_addr(mem_addr), .mem_dout(mem_dout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic ir, input logic [BITS-1:0] ia,
                       input logic dr, input logic [BITS-1:0] da);
      @(negedge clk);
      if_req = ir; if_addr = ia; ds_req = dr; ds_addr = da;
      #1;
   endtask

   initial begin
      logic prev_if, prev_ds;
      rst_n = 1'b0;
      if_req = 1'b1; if_addr = 32'h10; ds_req = 1'b1; ds_addr = 32'h20;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_ds_gnt", ds_gnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_ds_rvalid", ds_rvalid, 0);
      chk("rst_rdata", if_rdata | ds_rdata, 0);
      chk("rst_err", {if_err, ds_err}, 0);
      chk("rst_mem_addr", mem_addr, 0);

      // first grant immediately after release
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_ds_gnt", ds_gnt, 1);
      chk("rel_if_gnt", if_gnt, 0);
      step(0, 0, 0, 0);
      chk("rel_ds_rvalid", ds_rvalid, 1);
      chk("rel_ds_rdata", ds_rdata, rom(8));
      chk("rel_mem_addr", mem_addr, 32'h20);
      chk("rel_if_rvalid", if_rvalid, 0);

      // IF only
      step(1, 32'h10, 0, 0);
      chk("if_gnt", if_gnt, 1);
      chk("if_ds_gnt", ds_gnt, 0);
      step(0, 0, 0, 0);
      chk("if_mem_addr", mem_addr, 32'h10);
      chk("if_rvalid", if_rvalid, 1);
      chk("if_rdata", if_rdata, rom(4));
      chk("if_err", if_err, 0);
      chk("if_ds_rvalid", ds_rvalid, 0);
      step(0, 0, 0, 0);
      chk("if_idle_rvalid", if_rvalid, 0);
      chk("if_idle_rdata", if_rdata, 0);
      chk("if_idle_mem_addr", mem_addr, 32'h10);

      // contention: DS x4, forced IF, DS again
      prev_if = 1'b0; prev_ds = 1'b0;
      for (int c = 0; c < 7; c++) begin
         if (c < 6) step(1, 32'h0, 1, 32'h20);
         else       step(0, 0, 0, 0);
         if (c < 6) begin
            chk($sformatf("cont_ds_gnt_%0d", c), ds_gnt, (c != 4));
            chk($sformatf("cont_if_gnt_%0d", c), if_gnt, (c == 4));
         end
         if (c > 0) begin
            chk($sformatf("cont_ds_rvalid_%0d", c), ds_rvalid, prev_ds);
            chk($sformatf("cont_if_rvalid_%0d", c), if_rvalid, prev_if);
            chk($sformatf("cont_rdata_%0d", c), prev_if ? if_rdata : ds_rdata,
                prev_if ? rom(0) : rom(8));
         end
         prev_ds = (c < 6) && (c != 4);
         prev_if = (c == 4);
      end

      // DS streaming
      for (int k = 0; k < 4; k++) begin
         step(0, 0, k < 3, 32'(k * 4));
         if (k < 3) chk($sformatf("strm_gnt_%0d", k), ds_gnt, 1);
         if (k > 0) begin
            chk($sformatf("strm_rvalid_%0d", k), ds_rvalid, 1);
            chk($sformatf("strm_rdata_%0d", k), ds_rdata, rom(32'(k - 1)));
         end
      end
      step(0, 0, 0, 0);
      chk("strm_end_rvalid", ds_rvalid, 0);

      // faults: misaligned, then out of range
      step(0, 0, 1, 32'h6);
      step(0, 0, 1, 32'(DEPTH * 4));
      chk("flt_mis_rvalid", ds_rvalid, 1);
      chk("flt_mis_err", ds_err, 1);
      chk("flt_mis_rdata", ds_rdata, 0);
      step(0, 0, 0, 0);
      chk("flt_oor_rvalid", ds_rvalid, 1);
      chk("flt_oor_err", ds_err, 1);
      chk("flt_oor_rdata", ds_rdata, 0);
      chk("flt_oor_mem_addr", mem_addr, 32'(DEPTH * 4));
      step(0, 0, 0, 0);
      chk("flt_idle_err", ds_err, 0);

      // reset in the response cycle of an IF grant
      step(1, 32'h10, 0, 0);
      chk("rr_if_gnt", if_gnt, 1);
      @(negedge clk);
      if_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rr_if_rvalid", if_rvalid, 0);
      chk("rr_mem_addr", mem_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rr_after_rvalid", if_rvalid, 0);
      step(0, 0, 0, 0);
      chk("rr_after2_rvalid", if_rvalid | ds_rvalid, 0);
      step(1, 32'h8, 0, 0);
      chk("rr_new_gnt", if_gnt, 1);
      step(0, 0, 0, 0);
      chk("rr_new_rvalid", if_rvalid, 1);
      chk("rr_new_rdata", if_rdata, rom(2));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
